recirculation_mux_tx: RTL and testbench

Source-side (domain A) controller for the recirculation-mux CDC path. It accepts a word from an upstream valid/ready interface and holds it stable on a data bus that the domain-B capture side samples. It signals each new word by toggling a request level, then waits for the returned acknowledge toggle before accepting the next word. This gives the domain-B mux a data-stable guarantee and gives domain A back-pressure.

---
 rtl/recirculation_mux_pkg.sv | 13 +
 rtl/recirculation_mux_tx_sync.sv | 22 ++
 rtl/recirculation_mux_tx.sv | 94 +++++++++
 tb/tb_recirculation_mux_tx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/recirculation_mux_pkg.sv
// Shared types for the recirculation-mux CDC path (source and capture sides).
package recirculation_mux_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        WAIT_ACK = 2'd2
    } mux_tx_state_e;

    // Fewer than two flops leaves the acknowledge path exposed to metastability.
    localparam int MIN_STAGES = 2;

endpackage

// File: rtl/recirculation_mux_tx_sync.sv
// Multi-flop level synchronizer, reset to 0; only the last flop is exported.
module level_synchronizer #(
    parameter int G_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [G_STAGES-1:0] sync_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sync_pipe <= '0;
        else
            sync_pipe <= {sync_pipe[G_STAGES-2:0], d};
    end

    assign q = sync_pipe[G_STAGES-1];

endmodule

// File: rtl/recirculation_mux_tx.sv
// Domain-A source side of the recirculation mux: holds a word, toggles req,
// and waits for the synchronized ack toggle before taking the next word.
module recirculation_mux_tx
    import recirculation_mux_pkg::*;
#(
    parameter int g_stages    = 2,
    parameter int g_width     = 4,
    parameter int g_timeout   = 64,
    parameter int g_cnt_width = 16
) (
    input  logic                   i_clk_A,
    input  logic                   i_rst_A,
    input  logic                   i_valid_A,
    output logic                   o_ready_A,
    input  logic [g_width-1:0]     i_data_A,
    output logic [g_width-1:0]     o_data_A,
    output logic                   o_req_toggle_A,
    input  logic                   i_ack_toggle_B,
    output logic                   o_busy_A,
    output logic                   o_done_A,
    output logic                   o_timeout_A,
    output logic [g_cnt_width-1:0] o_xfer_count_A
);

    localparam int TW = (g_timeout > 0) ? $clog2(g_timeout + 1) : 1;
    localparam logic [TW-1:0] TLIM = TW'(g_timeout);

    generate
        if (g_stages < MIN_STAGES) begin : g_bad_stages
            $error("recirculation_mux_tx: g_stages must be >= 2");
        end
    endgenerate

    mux_tx_state_e state;
    logic          ack_sync;
    logic [TW-1:0] tmo_cnt;

    level_synchronizer #(
        .G_STAGES (g_stages)
    ) u_ack_sync (
        .clk (i_clk_A),
        .rst (i_rst_A),
        .d   (i_ack_toggle_B),
        .q   (ack_sync)
    );

    assign o_ready_A = (state == IDLE);
    assign o_busy_A  = (state != IDLE);

    always_ff @(posedge i_clk_A or posedge i_rst_A) begin
        if (i_rst_A) begin
            state          <= IDLE;
            o_data_A       <= '0;
            o_req_toggle_A <= 1'b0;
            o_done_A       <= 1'b0;
            o_timeout_A    <= 1'b0;
            o_xfer_count_A <= '0;
            tmo_cnt        <= '0;
        end else begin
            o_done_A <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid_A) begin
                        o_data_A <= i_data_A;
                        state    <= HOLD;
                    end
                end
                // One full cycle of stable data before the request edge.
                HOLD: begin
                    o_req_toggle_A <= ~o_req_toggle_A;
                    state          <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    // Level compare: parity match means domain B has captured.
                    if (ack_sync == o_req_toggle_A) begin
                        state          <= IDLE;
                        o_done_A       <= 1'b1;
                        o_xfer_count_A <= o_xfer_count_A + 1'b1;
                        tmo_cnt        <= '0;
                    end else if (g_timeout > 0) begin
                        // Never abort: aborting would break req/ack parity.
                        if (tmo_cnt != TLIM) begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                            if (tmo_cnt == TLIM - 1'b1)
                                o_timeout_A <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_recirculation_mux_tx.sv
// Bench for recirculation_mux_tx with a delayed ack loopback and a data scoreboard.
module tb_recirculation_mux_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic       ready;
    logic [3:0] din;
    logic [3:0] dout;
    logic       req;
    logic       ack_b;
    logic       busy;
    logic       done;
    logic       tmo;
    logic [1:0] cnt;

    recirculation_mux_tx #(
        .g_stages    (2),
        .g_width     (4),
        .g_timeout   (8),
        .g_cnt_width (2)
    ) dut (
        .i_clk_A        (clk),
        .i_rst_A        (rst),
        .i_valid_A      (valid),
        .o_ready_A      (ready),
        .i_data_A       (din),
        .o_data_A       (dout),
        .o_req_toggle_A (req),
        .i_ack_toggle_B (ack_b),
        .o_busy_A       (busy),
        .o_done_A       (done),
        .o_timeout_A    (tmo),
        .o_xfer_count_A (cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Domain-B model: ack follows req after ack_dly cycles unless withheld.
    logic [7:0] hist;
    int         ack_dly  = 3;
    bit         withhold = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) hist <= '0;
        else     hist <= {hist[6:0], req};
    end

    always @(negedge clk or posedge rst) begin
        if (rst)            ack_b <= 1'b0;
        else if (!withhold) ack_b <= hist[ack_dly-1];
    end

    // Scoreboard: words pushed on accept, popped on done.
    logic [3:0] exp_q[$];
    logic [3:0] cur_word;
    logic [1:0] exp_cnt;
    logic       exp_req;
    int         done_seen;

    task automatic clear_model();
        exp_q.delete();
        cur_word = 4'h0;
        exp_cnt  = 2'd0;
        exp_req  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (busy) chk("hold_data", dout, cur_word);
            if (done) begin
                done_seen++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL done_unexpected: done with empty queue, data %0h", dout);
                end else begin
                    logic [3:0] w;
                    w = exp_q.pop_front();
                    exp_cnt++;
                    exp_req = ~exp_req;
                    chk("done_data", dout, w);
                    chk("done_count", cnt, exp_cnt);
                    chk("done_req", req, exp_req);
                end
            end
        end
    end

    task automatic reset_dut();
        rst = 1'b1;
        clear_model();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Returns at the negedge after the accepting edge (block in HOLD).
    task automatic send(input logic [3:0] d, input bit keep);
        int n;
        valid = 1'b1;
        din   = d;
        n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_checks++;
            $display("FAIL send_timeout: ready stayed 0 for word %0h", d);
        end
        exp_q.push_back(d);
        cur_word = d;
        @(negedge clk);
        if (!keep) valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL wait_done: no done within %0d cycles", n);
        end
    endtask

    typedef struct {
        logic [3:0] d;
        logic       exp_req;
        logic [1:0] exp_cnt;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int n;
        int d0;
        tbl[0] = '{4'h1, 1'b1, 2'd1};
        tbl[1] = '{4'hE, 1'b0, 2'd2};
        tbl[2] = '{4'h7, 1'b1, 2'd3};
        tbl[3] = '{4'h0, 1'b0, 2'd0};
        tbl[4] = '{4'hB, 1'b1, 2'd1};

        valid = 1'b0;
        din   = 4'h0;
        done_seen = 0;
        reset_dut();

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            chk("reset_idle", {ready, req, busy, dout, cnt, tmo}, {1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0});
            @(negedge clk);
        end

        // Single transfer
        d0 = done_seen;
        send(4'hA, 1'b0);
        chk("hold_state", {ready, busy, req, dout}, {1'b0, 1'b1, 1'b0, 4'hA});
        @(negedge clk);
        chk("req_edge", {req, dout}, {1'b1, 4'hA});
        wait_done(n);
        chk("ack_latency_ok", (n >= 4 && n <= 8), 1);
        chk("single_count", cnt, 2'd1);
        chk("single_ready", ready, 1'b1);
        @(negedge clk);
        chk("done_pulse_clear", done, 1'b0);
        repeat (5) @(negedge clk);
        chk("single_done_pulses", done_seen - d0, 1);

        // Back-to-back valid held high
        d0 = done_seen;
        send(4'hA, 1'b1);
        send(4'h5, 1'b1);
        send(4'hC, 1'b0);
        @(negedge clk);
        wait_done(n);
        repeat (5) @(negedge clk);
        chk("b2b_transfers", done_seen - d0, 3);
        chk("b2b_count", cnt, 2'd0);
        chk("b2b_req", req, 1'b0);
        chk("b2b_last_data", dout, 4'hC);

        // Ack withheld -> sticky timeout, then completion
        withhold = 1'b1;
        send(4'h3, 1'b0);
        @(negedge clk);
        repeat (5) @(negedge clk);
        chk("timeout_early", tmo, 1'b0);
        repeat (4) @(negedge clk);
        chk("timeout_set", {tmo, busy}, {1'b1, 1'b1});
        withhold = 1'b0;
        wait_done(n);
        chk("timeout_complete_count", cnt, 2'd1);
        @(negedge clk);
        chk("timeout_sticky", {tmo, ready}, {1'b1, 1'b1});

        // Asynchronous reset mid-WAIT_ACK
        send(4'h9, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        clear_model();
        #1;
        chk("async_reset", {ready, busy, req, dout, done, tmo, cnt}, {1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0});
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(4'h6, 1'b0);
        @(negedge clk);
        chk("post_reset_req", req, 1'b1);
        wait_done(n);
        chk("post_reset_count", {cnt, dout}, {2'd1, 4'h6});

        // Counter wrap, table-driven
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            send(tbl[i].d, 1'b0);
            wait_done(n);
            chk("tbl_count", cnt, tbl[i].exp_cnt);
            chk("tbl_req", req, tbl[i].exp_req);
            chk("tbl_data", dout, tbl[i].d);
        end
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
